// File: rtl/xm_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decoder and control-unit signals.
//   memReq_o/memAdr_o     : instruction read request and even fetch address
//   memRdy_i/memData_i    : memory accepts the request and returns data in the same cycle
//   inst_o/instValid_o    : instruction register and its unconsumed flag
//   instAck_i             : control unit consumes inst_o
//   pc_o/pcNext_o         : address of inst_o and that address + 2
//   pcLoad_i/pcVal_i      : PC redirect request and target
// Modports: master = fetch unit side, slave = memory/control side.
interface xm_fetch_unit_if #(
  parameter int unsigned WORD = 16
);
  logic            memReq_o;
  logic [WORD-1:0] memAdr_o;
  logic            memRdy_i;
  logic [WORD-1:0] memData_i;
  logic [WORD-1:0] inst_o;
  logic            instValid_o;
  logic            instAck_i;
  logic [WORD-1:0] pc_o;
  logic [WORD-1:0] pcNext_o;
  logic            pcLoad_i;
  logic [WORD-1:0] pcVal_i;

  modport master (
    output memReq_o, memAdr_o, inst_o, instValid_o, pc_o, pcNext_o,
    input  memRdy_i, memData_i, instAck_i, pcLoad_i, pcVal_i
  );

  modport slave (
    input  memReq_o, memAdr_o, inst_o, instValid_o, pc_o, pcNext_o,
    output memRdy_i, memData_i, instAck_i, pcLoad_i, pcVal_i
  );
endinterface

// File: rtl/xm_fetch_unit.sv
// Instruction fetch stage of the multi-cycle XMakina core. Owns the program counter and the
// instruction register, issues 16-bit reads and hands instructions to the control unit with a
// valid/ack handshake. Accepts PC redirects (branch/link/trap) at any time.
// Ports:
//   clk_i  : clock, rising edge
//   arst_i : asynchronous active-high reset
//   bus    : xm_fetch_unit_if.master (memory request, instruction/pc outputs, ack, redirect)
// Build option: define XM_FETCH_PREFETCH_EN to add a one-entry prefetch buffer that lets
// back-to-back acks consume one instruction per cycle.
module xm_fetch_unit #(
  parameter int unsigned     WORD      = 16,
  parameter logic [WORD-1:0] RESET_VEC = '0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  xm_fetch_unit_if.master  bus
);

  localparam logic [WORD-1:0] ResetAdr = {RESET_VEC[WORD-1:1], 1'b0};

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [WORD-1:0] fetch_adr_q, fetch_adr_d;
  logic [WORD-1:0] redir_q, redir_d;       // target latched while an old request drains
  logic [WORD-1:0] inst_q, inst_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            mem_req;
  logic [WORD-1:0] target;
  logic [WORD-1:0] adr_inc;

`ifdef XM_FETCH_PREFETCH_EN
  logic [WORD-1:0] buf_q, buf_d;
  logic [WORD-1:0] buf_pc_q, buf_pc_d;
  logic            buf_valid_q, buf_valid_d;
`endif

  assign target  = bus.pcVal_i & ~WORD'(1);
  assign adr_inc = fetch_adr_q + WORD'(2);

  // Request decoded from state and registers only; no input feeds it.
  always_comb begin
    mem_req = 1'b0;
    unique case (state_q)
      StFetch, StDiscard: mem_req = 1'b1;
`ifdef XM_FETCH_PREFETCH_EN
      StHold:             mem_req = ~buf_valid_q;
`endif
      default:            mem_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fetch_adr_d = fetch_adr_q;
    redir_d     = redir_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
`ifdef XM_FETCH_PREFETCH_EN
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.pcLoad_i) fetch_adr_d = target;
        state_d = StFetch;
      end

      StFetch: begin
        if (bus.pcLoad_i) begin
          valid_d = 1'b0;
          if (bus.memRdy_i) begin
            fetch_adr_d = target;      // returned word is dropped
          end else begin
            redir_d = target;          // request cannot be withdrawn
            state_d = StDiscard;
          end
        end else if (bus.memRdy_i) begin
          inst_d      = bus.memData_i;
          pc_d        = fetch_adr_q;
          fetch_adr_d = adr_inc;
          valid_d     = 1'b1;
          state_d     = StHold;
        end
      end

      StHold: begin
`ifdef XM_FETCH_PREFETCH_EN
        if (bus.pcLoad_i) begin
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          if (mem_req && !bus.memRdy_i) begin
            redir_d = target;
            state_d = StDiscard;
          end else begin
            fetch_adr_d = target;
            state_d     = StFetch;
          end
        end else if (bus.instAck_i) begin
          if (buf_valid_q) begin
            inst_d      = buf_q;
            pc_d        = buf_pc_q;
            buf_valid_d = 1'b0;
          end else if (mem_req && bus.memRdy_i) begin
            // Word arriving with the ack bypasses the buffer straight into the IR.
            inst_d      = bus.memData_i;
            pc_d        = fetch_adr_q;
            fetch_adr_d = adr_inc;
          end else begin
            valid_d = 1'b0;
            state_d = StFetch;         // keeps the same request going
          end
        end else if (mem_req && bus.memRdy_i) begin
          buf_d       = bus.memData_i;
          buf_pc_d    = fetch_adr_q;
          fetch_adr_d = adr_inc;
          buf_valid_d = 1'b1;
        end
`else
        if (bus.pcLoad_i) begin
          valid_d     = 1'b0;
          fetch_adr_d = target;
          state_d     = StFetch;
        end else if (bus.instAck_i) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
`endif
      end

      StDiscard: begin
        if (bus.memRdy_i) begin
          fetch_adr_d = bus.pcLoad_i ? target : redir_q;
          state_d     = StFetch;
        end else if (bus.pcLoad_i) begin
          redir_d = target;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StIdle;
      fetch_adr_q <= ResetAdr;
      redir_q     <= ResetAdr;
      inst_q      <= '0;
      pc_q        <= ResetAdr;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_adr_q <= fetch_adr_d;
      redir_q     <= redir_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

`ifdef XM_FETCH_PREFETCH_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      buf_q       <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`endif

  assign bus.memReq_o    = mem_req;
  assign bus.memAdr_o    = fetch_adr_q;
  assign bus.inst_o      = inst_q;
  assign bus.instValid_o = valid_q;
  assign bus.pc_o        = pc_q;
  assign bus.pcNext_o    = pc_q + WORD'(2);

endmodule

// File: tb/tb_xm_fetch_unit.sv
module tb_xm_fetch_unit;
  localparam int unsigned WORD = 16;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  xm_fetch_unit_if #(.WORD(WORD)) bus ();

  xm_fetch_unit #(
    .WORD     (WORD),
    .RESET_VEC(16'h0101)
  ) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic drive(input logic rdy, input logic [15:0] data, input logic ack,
                       input logic load, input logic [15:0] val);
    bus.memRdy_i  = rdy;
    bus.memData_i = data;
    bus.instAck_i = ack;
    bus.pcLoad_i  = load;
    bus.pcVal_i   = val;
  endtask

  logic [15:0] exp_pc;
  logic [15:0] prev_adr;
  logic        prev_req, prev_rdy, prev_load;
  logic        r_rdy, r_ack, r_load;
  logic [15:0] r_data, r_val;
  int          delivered;

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    check("rst_req", 16'(bus.memReq_o), 16'h0);
    check("rst_adr", bus.memAdr_o, 16'h0100);
    check("rst_inst", bus.inst_o, 16'h0);
    check("rst_valid", 16'(bus.instValid_o), 16'h0);
    check("rst_pc", bus.pc_o, 16'h0100);
    check("rst_pcnext", bus.pcNext_o, 16'h0102);
    arst = 1'b0;
    @(negedge clk);
    check("first_req", 16'(bus.memReq_o), 16'h1);
    check("first_adr", bus.memAdr_o, 16'h0100);

`ifndef XM_FETCH_PREFETCH_EN
    drive(1'b1, 16'h4C0A, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("cap_valid", 16'(bus.instValid_o), 16'h1);
    check("cap_inst", bus.inst_o, 16'h4C0A);
    check("cap_pc", bus.pc_o, 16'h0100);
    check("cap_pcnext", bus.pcNext_o, 16'h0102);
    check("hold_req", 16'(bus.memReq_o), 16'h0);

    // Three wait states.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    bus.instAck_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("ws_req", 16'(bus.memReq_o), 16'h1);
      check("ws_adr", bus.memAdr_o, 16'h0102);
      check("ws_valid", 16'(bus.instValid_o), 16'h0);
      if (k == 3) drive(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
    end
    bus.memRdy_i = 1'b0;
    check("ws_cap_valid", 16'(bus.instValid_o), 16'h1);
    check("ws_cap_pc", bus.pc_o, 16'h0102);
    check("ws_cap_inst", bus.inst_o, 16'h1234);

    // Redirect while a request is outstanding.
    bus.instAck_i = 1'b1;
    @(negedge clk);
    check("rd_pre_adr", bus.memAdr_o, 16'h0104);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h2001);
    @(negedge clk);
    check("disc_req", 16'(bus.memReq_o), 16'h1);
    check("disc_adr", bus.memAdr_o, 16'h0104);
    check("disc_valid", 16'(bus.instValid_o), 16'h0);
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("rd_req", 16'(bus.memReq_o), 16'h1);
    check("rd_adr", bus.memAdr_o, 16'h2000);
    check("rd_valid", 16'(bus.instValid_o), 16'h0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("rd_cap_valid", 16'(bus.instValid_o), 16'h1);
    check("rd_cap_pc", bus.pc_o, 16'h2000);
    check("rd_cap_inst", bus.inst_o, 16'h2222);

    // Redirect and ack together in HOLD.
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h3000);
    @(negedge clk);
    check("la_valid", 16'(bus.instValid_o), 16'h0);
    check("la_req", 16'(bus.memReq_o), 16'h1);
    check("la_adr", bus.memAdr_o, 16'h3000);

    // Redirect in FETCH with ready: data dropped, fetch goes to FFFE.
    drive(1'b1, 16'hBEEF, 1'b0, 1'b1, 16'hFFFF);
    @(negedge clk);
    check("fr_valid", 16'(bus.instValid_o), 16'h0);
    check("fr_adr", bus.memAdr_o, 16'hFFFE);
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("wrap_valid", 16'(bus.instValid_o), 16'h1);
    check("wrap_pc", bus.pc_o, 16'hFFFE);
    check("wrap_pcnext", bus.pcNext_o, 16'h0000);
    check("wrap_inst", bus.inst_o, 16'h7777);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("wrap_req", 16'(bus.memReq_o), 16'h1);
    check("wrap_adr", bus.memAdr_o, 16'h0000);
`else
    drive(1'b1, mem_word(16'h0100), 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("pf_valid0", 16'(bus.instValid_o), 16'h1);
    check("pf_pc0", bus.pc_o, 16'h0100);
    check("pf_req", 16'(bus.memReq_o), 16'h1);
    check("pf_adr", bus.memAdr_o, 16'h0102);
    for (int k = 1; k <= 8; k++) begin
      drive(bus.memReq_o, mem_word(bus.memAdr_o), 1'b1, 1'b0, 16'h0);
      @(negedge clk);
      check("pf_valid", 16'(bus.instValid_o), 16'h1);
      check("pf_pc", bus.pc_o, 16'(16'h0100 + 2 * k));
      check("pf_inst", bus.inst_o, mem_word(16'(16'h0100 + 2 * k)));
    end
`endif

    // Randomized run against an instruction-stream model.
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    exp_pc    = 16'h0100;
    prev_req  = 1'b0;
    prev_rdy  = 1'b0;
    prev_load = 1'b0;
    prev_adr  = 16'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (prev_load) check("flush_valid", 16'(bus.instValid_o), 16'h0);
      if (prev_req && !prev_rdy) begin
        check("stable_req", 16'(bus.memReq_o), 16'h1);
        check("stable_adr", bus.memAdr_o, prev_adr);
      end
      if (bus.memReq_o) check("even_adr", 16'(bus.memAdr_o[0]), 16'h0);
      if (bus.instValid_o) begin
        check("rnd_pc", bus.pc_o, exp_pc);
        check("rnd_inst", bus.inst_o, mem_word(exp_pc));
        check("rnd_pcnext", bus.pcNext_o, 16'(exp_pc + 16'h2));
      end
      r_rdy  = bus.memReq_o && ($urandom_range(2) != 0);
      r_data = r_rdy ? mem_word(bus.memAdr_o) : 16'($urandom);
      r_ack  = 1'($urandom_range(1));
      r_load = ($urandom_range(15) == 0);
      r_val  = 16'($urandom);
      drive(r_rdy, r_data, r_ack, r_load, r_val);
      if (r_load) begin
        exp_pc = r_val & 16'hFFFE;
      end else if (r_ack && bus.instValid_o) begin
        exp_pc = exp_pc + 16'h2;
        delivered++;
      end
      prev_req  = bus.memReq_o;
      prev_rdy  = r_rdy;
      prev_load = r_load;
      prev_adr  = bus.memAdr_o;
    end
    check("progress", 16'(delivered > 200), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
